cw305_reg_arbiter: RTL and testbench
====================================

# cw305_reg_arbiter

Shares the CW305 register bus between the USB register front-end and one on-chip master (e.g. the ECG sequencer's config/readback engine). USB traffic cannot be stalled, so it always owns the bus. The internal master gets single-byte transactions only in USB idle gaps, qualified by an idle-guard window. Transactions that collide with USB traffic are aborted and flagged. The block sits between the USB front-end outputs and the register-decode slaves.

## Interface

Parameters:
- pADDR_WIDTH, 21, full USB address width
- pBYTECNT_SIZE, 7, byte-count field width; register address width AW = pADDR_WIDTH-pBYTECNT_SIZE
- pIDLE_GUARD, 4, consecutive idle cycles required before a grant (≥2)

Ports:
- usb_clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- u_cen_early  in  1  raw usb_cen pin, active low; early USB-activity indication
- u_address / u_bytecnt / u_datao  in  AW / pBYTECNT_SIZE / 8  front-end register-bus outputs
- u_read / u_write / u_addrvalid  in  1 each  front-end strobes
- u_datai  out  8  read data to front-end; always equals reg_datai
- m_req  in  1  internal request; held until m_gnt
- m_we  in  1  1 = write, 0 = read
- m_address / m_bytecnt / m_wdata  in  AW / pBYTECNT_SIZE / 8  transaction fields
- m_gnt  out  1  one-cycle pulse: transaction issued
- m_done  out  1  one-cycle pulse: transaction finished
- m_err  out  1  valid with m_done; 1 = aborted by USB collision
- m_rdata  out  8  read data, valid from m_done until the next read completes
- abort_cnt  out  8  saturating count of aborts
- reg_address / reg_bytecnt / reg_datao  out  AW / pBYTECNT_SIZE / 8  shared bus
- reg_read / reg_write / reg_addrvalid  out  1 each  shared bus strobes
- reg_datai  in  8  slave read data, valid one cycle after reg_read

## Operation

- FSM states: IDLE, ISSUE, CAPT, DONE.
- Guard counter: increments while u_cen_early=1 and u_read=u_write=0. Saturates at pIDLE_GUARD. Clears otherwise.
- IDLE -> ISSUE when m_req=1, guard saturated and u_cen_early=1. Fields are latched that cycle.
- ISSUE (m_gnt=1): drives latched fields.
  - Write: reg_write=1 for one cycle -> DONE.
  - Read: reg_read=1 for one cycle -> CAPT.
- CAPT: holds the latched address with strobes low, latches reg_datai into m_rdata, -> DONE.
- DONE: m_done=1 -> IDLE.
- Bus mux: when u_read|u_write, the bus carries the USB fields (reg_addrvalid=u_addrvalid). Otherwise it carries the internal fields in ISSUE/CAPT, and the USB fields in IDLE/DONE. When the internal master drives, reg_addrvalid=1.
- Collision in ISSUE or CAPT (u_read|u_write=1):
  - Internal strobes are suppressed; m_rdata is unchanged.
  - The FSM goes to DONE with m_err=1; abort_cnt increments, saturating at 255.
- m_req deasserted before grant: nothing is issued. Requests are sampled only in IDLE.

## Timing

- Reset values: state IDLE, guard 0, m_gnt/m_done/m_err 0, m_rdata 0x00, abort_cnt 0.
- Internal strobes are 0 in reset; the USB path passes through combinationally during reset.
- rst mid-transaction: returns to IDLE next cycle with no m_done.
- Request sampled at cycle T:
  - Write: m_gnt and reg_write at T+1, m_done at T+2.
  - Read: m_gnt and reg_read at T+1, capture at T+2, m_done and m_rdata at T+3.
- Back-to-back: the next request can be sampled in IDLE at T+3 (write) or T+4 (read), provided the guard is still saturated.
- USB passthrough adds zero cycles.

## Structure

- Package cw305_reg_arb_pkg: FSM state encoding; owner constants OWN_USB and OWN_INT.
- Natural sub-module: cw305_bus_idle_detect, containing the guard counter and the saturation flag.

## Test plan

- Idle bus, guard saturated; internal write addr 0x12, byte 3, data 0xA5 -> reg_write at T+1 carrying those fields; m_done at T+2 with m_err=0.
- Internal read of a slave returning 0x3C -> reg_read at T+1; m_rdata=0x3C with m_done at T+3.
- USB write 0x77 to addr 0x05 while m_req held -> USB bus values pass unchanged; m_gnt only after u_cen_early has been high for 4 idle cycles.
- u_read rises during CAPT -> m_done with m_err=1, m_rdata unchanged, abort_cnt=1; the bus shows the USB address that cycle.
- 300 forced collisions -> abort_cnt saturates at 255.
- rst asserted in ISSUE -> IDLE next cycle, no m_done; all outputs at their reset values.

Source files
------------

// File: rtl/cw305_reg_arbiter_pkg.sv
// Shared types for the CW305 register-bus arbiter: FSM encoding, bus owner tags
// and a saturating counter helper.
package cw305_reg_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CAPT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_USB = 1'b0,
    OWN_INT = 1'b1
  } owner_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) begin
      r = 8'hFF;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cw305_reg_arbiter_if.sv
// Signal bundle around the arbiter: USB front-end side, internal master side and
// the shared register bus. "master" is the arbiter's view, "slave" is everything around it.
interface cw305_reg_arbiter_if #(
  parameter int AW = 14,
  parameter int BW = 7
);
  logic          u_cen_early;
  logic [AW-1:0] u_address;
  logic [BW-1:0] u_bytecnt;
  logic [7:0]    u_datao;
  logic          u_read;
  logic          u_write;
  logic          u_addrvalid;
  logic [7:0]    u_datai;

  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_address;
  logic [BW-1:0] m_bytecnt;
  logic [7:0]    m_wdata;
  logic          m_gnt;
  logic          m_done;
  logic          m_err;
  logic [7:0]    m_rdata;
  logic [7:0]    abort_cnt;

  logic [AW-1:0] reg_address;
  logic [BW-1:0] reg_bytecnt;
  logic [7:0]    reg_datao;
  logic          reg_read;
  logic          reg_write;
  logic          reg_addrvalid;
  logic [7:0]    reg_datai;

  modport master (
    input  u_cen_early, u_address, u_bytecnt, u_datao, u_read, u_write, u_addrvalid,
    output u_datai,
    input  m_req, m_we, m_address, m_bytecnt, m_wdata,
    output m_gnt, m_done, m_err, m_rdata, abort_cnt,
    output reg_address, reg_bytecnt, reg_datao, reg_read, reg_write, reg_addrvalid,
    input  reg_datai
  );

  modport slave (
    output u_cen_early, u_address, u_bytecnt, u_datao, u_read, u_write, u_addrvalid,
    input  u_datai,
    output m_req, m_we, m_address, m_bytecnt, m_wdata,
    input  m_gnt, m_done, m_err, m_rdata, abort_cnt,
    input  reg_address, reg_bytecnt, reg_datao, reg_read, reg_write, reg_addrvalid,
    output reg_datai
  );

endinterface

// File: rtl/cw305_reg_arbiter_bus_idle_detect.sv
// Counts consecutive USB-idle cycles and flags when the idle-guard window is met.
module cw305_bus_idle_detect #(
  parameter int pIDLE_GUARD = 4
) (
  input  logic usb_clk,
  input  logic rst,
  input  logic cen_early_i,
  input  logic usb_busy_i,
  output logic guard_sat_o
);

  localparam int GW = $clog2(pIDLE_GUARD + 1);
  localparam logic [GW-1:0] GUARD_MAX = GW'(pIDLE_GUARD);

  logic [GW-1:0] guard_q;
  logic [GW-1:0] guard_d;

  always_comb begin
    guard_d = guard_q;
    if (cen_early_i && !usb_busy_i) begin
      if (guard_q != GUARD_MAX) begin
        guard_d = guard_q + GW'(1);
      end else begin
        guard_d = guard_q;
      end
    end else begin
      guard_d = '0;
    end
  end

  always_ff @(posedge usb_clk) begin
    if (rst) begin
      guard_q <= '0;
    end else begin
      guard_q <= guard_d;
    end
  end

  assign guard_sat_o = (guard_q == GUARD_MAX);

endmodule

// File: rtl/cw305_reg_arbiter.sv
// Shares the CW305 register bus between the USB front-end (always wins) and one
// internal master issuing single-byte transactions in USB idle gaps.
module cw305_reg_arbiter
  import cw305_reg_arb_pkg::*;
#(
  parameter int pADDR_WIDTH   = 21,
  parameter int pBYTECNT_SIZE = 7,
  parameter int pIDLE_GUARD   = 4
) (
  input logic                usb_clk,
  input logic                rst,
  cw305_reg_arbiter_if.master bus
);

  localparam int AW = pADDR_WIDTH - pBYTECNT_SIZE;
  localparam int BW = pBYTECNT_SIZE;

  arb_state_e      state_q, state_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            err_q, err_d;
  logic [7:0]      rdata_q, rdata_d;
  logic [7:0]      abort_q, abort_d;

  logic            usb_busy;
  logic            guard_sat;
  owner_e          owner;
  logic            int_issue;

  assign usb_busy = bus.u_read | bus.u_write;

  cw305_bus_idle_detect #(
    .pIDLE_GUARD (pIDLE_GUARD)
  ) u_idle (
    .usb_clk     (usb_clk),
    .rst         (rst),
    .cen_early_i (bus.u_cen_early),
    .usb_busy_i  (usb_busy),
    .guard_sat_o (guard_sat)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    bcnt_d  = bcnt_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    abort_d = abort_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.m_req && guard_sat && bus.u_cen_early) begin
          state_d = ST_ISSUE;
          we_d    = bus.m_we;
          addr_d  = bus.m_address;
          bcnt_d  = bus.m_bytecnt;
          wdata_d = bus.m_wdata;
          err_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (usb_busy) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
          abort_d = sat_inc8(abort_q);
        end else if (we_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_CAPT;
        end
      end
      ST_CAPT: begin
        // A collision here leaves the previous read data in place.
        if (usb_busy) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
          abort_d = sat_inc8(abort_q);
        end else begin
          state_d = ST_DONE;
          rdata_d = bus.reg_datai;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge usb_clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      bcnt_q  <= '0;
      wdata_q <= 8'h00;
      err_q   <= 1'b0;
      rdata_q <= 8'h00;
      abort_q <= 8'h00;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      bcnt_q  <= bcnt_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      abort_q <= abort_d;
    end
  end

  // USB strobes always take the bus; the internal master only drives it in ISSUE/CAPT.
  always_comb begin
    owner = OWN_USB;
    if (!rst && !usb_busy && (state_q == ST_ISSUE || state_q == ST_CAPT)) begin
      owner = OWN_INT;
    end else begin
      owner = OWN_USB;
    end
  end

  assign int_issue = (owner == OWN_INT) && (state_q == ST_ISSUE);

  always_comb begin
    bus.reg_address   = bus.u_address;
    bus.reg_bytecnt   = bus.u_bytecnt;
    bus.reg_datao     = bus.u_datao;
    bus.reg_read      = bus.u_read;
    bus.reg_write     = bus.u_write;
    bus.reg_addrvalid = bus.u_addrvalid;
    if (owner == OWN_INT) begin
      bus.reg_address   = addr_q;
      bus.reg_bytecnt   = bcnt_q;
      bus.reg_datao     = wdata_q;
      bus.reg_read      = int_issue && !we_q;
      bus.reg_write     = int_issue && we_q;
      bus.reg_addrvalid = 1'b1;
    end else begin
      bus.reg_address   = bus.u_address;
    end
  end

  assign bus.u_datai   = bus.reg_datai;
  assign bus.m_gnt     = !rst && (state_q == ST_ISSUE);
  assign bus.m_done    = !rst && (state_q == ST_DONE);
  assign bus.m_err     = !rst && (state_q == ST_DONE) && err_q;
  assign bus.m_rdata   = rdata_q;
  assign bus.abort_cnt = abort_q;

endmodule

// File: tb/tb_cw305_reg_arbiter.sv
// Directed bench for cw305_reg_arbiter: reset, guard window, write, read, collision,
// abort saturation and mid-transaction reset.
module tb_cw305_reg_arbiter;

  localparam int AW = 14;
  localparam int BW = 7;

  logic usb_clk;
  logic rst;
  int   nvec;
  int   nerr;
  logic got;

  cw305_reg_arbiter_if #(.AW(AW), .BW(BW)) bus ();

  cw305_reg_arbiter #(
    .pADDR_WIDTH   (21),
    .pBYTECNT_SIZE (7),
    .pIDLE_GUARD   (4)
  ) dut (
    .usb_clk (usb_clk),
    .rst     (rst),
    .bus     (bus)
  );

  initial usb_clk = 1'b0;
  always #5 usb_clk = ~usb_clk;

  task automatic step();
    @(posedge usb_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_gnt();
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (!got) begin
        step();
        if (bus.m_gnt === 1'b1) got = 1'b1;
      end
    end
    chk("gnt_wait", {31'd0, got}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nvec = 0;
    nerr = 0;
    rst = 1'b1;
    bus.u_cen_early = 1'b1;
    bus.u_address = 14'h0000;
    bus.u_bytecnt = 7'h00;
    bus.u_datao = 8'h00;
    bus.u_read = 1'b0;
    bus.u_write = 1'b0;
    bus.u_addrvalid = 1'b0;
    bus.m_req = 1'b0;
    bus.m_we = 1'b0;
    bus.m_address = 14'h0000;
    bus.m_bytecnt = 7'h00;
    bus.m_wdata = 8'h00;
    bus.reg_datai = 8'h00;
    step();
    step();

    // reset values
    chk("rst_gnt", {31'd0, bus.m_gnt}, 32'd0);
    chk("rst_done", {31'd0, bus.m_done}, 32'd0);
    chk("rst_err", {31'd0, bus.m_err}, 32'd0);
    chk("rst_rdata", {24'd0, bus.m_rdata}, 32'h00);
    chk("rst_abort", {24'd0, bus.abort_cnt}, 32'h00);
    chk("rst_regwr", {31'd0, bus.reg_write}, 32'd0);

    // USB write passes through while still in reset
    bus.u_cen_early = 1'b0;
    bus.u_write = 1'b1;
    bus.u_address = 14'h0005;
    bus.u_datao = 8'h77;
    bus.u_bytecnt = 7'h01;
    bus.u_addrvalid = 1'b1;
    #1;
    chk("rst_pass_wr", {31'd0, bus.reg_write}, 32'd1);
    chk("rst_pass_addr", {18'd0, bus.reg_address}, 32'h5);
    chk("rst_pass_data", {24'd0, bus.reg_datao}, 32'h77);

    // internal write pending while USB is busy
    bus.m_req = 1'b1;
    bus.m_we = 1'b1;
    bus.m_address = 14'h0012;
    bus.m_bytecnt = 7'h03;
    bus.m_wdata = 8'hA5;
    rst = 1'b0;
    step();
    chk("usb_wr", {31'd0, bus.reg_write}, 32'd1);
    chk("usb_addr", {18'd0, bus.reg_address}, 32'h5);
    chk("usb_data", {24'd0, bus.reg_datao}, 32'h77);
    chk("usb_av", {31'd0, bus.reg_addrvalid}, 32'd1);
    chk("usb_nognt", {31'd0, bus.m_gnt}, 32'd0);

    bus.u_write = 1'b0;
    bus.u_addrvalid = 1'b0;
    bus.u_cen_early = 1'b1;
    bus.u_address = 14'h0000;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("guard_nognt", {31'd0, bus.m_gnt}, 32'd0);
    end

    // ISSUE: write strobe with latched fields
    step();
    chk("wr_gnt", {31'd0, bus.m_gnt}, 32'd1);
    chk("wr_strobe", {31'd0, bus.reg_write}, 32'd1);
    chk("wr_rd0", {31'd0, bus.reg_read}, 32'd0);
    chk("wr_addr", {18'd0, bus.reg_address}, 32'h12);
    chk("wr_bcnt", {25'd0, bus.reg_bytecnt}, 32'h3);
    chk("wr_data", {24'd0, bus.reg_datao}, 32'hA5);
    chk("wr_av", {31'd0, bus.reg_addrvalid}, 32'd1);
    bus.m_req = 1'b0;
    step();
    chk("wr_done", {31'd0, bus.m_done}, 32'd1);
    chk("wr_err", {31'd0, bus.m_err}, 32'd0);
    chk("wr_strobe_off", {31'd0, bus.reg_write}, 32'd0);
    step();
    chk("wr_done_off", {31'd0, bus.m_done}, 32'd0);

    // back-to-back internal read, slave returns 0x3C
    bus.m_req = 1'b1;
    bus.m_we = 1'b0;
    bus.m_address = 14'h0021;
    bus.m_bytecnt = 7'h01;
    bus.reg_datai = 8'h3C;
    step();
    chk("rd_gnt", {31'd0, bus.m_gnt}, 32'd1);
    chk("rd_strobe", {31'd0, bus.reg_read}, 32'd1);
    chk("rd_wr0", {31'd0, bus.reg_write}, 32'd0);
    chk("rd_addr", {18'd0, bus.reg_address}, 32'h21);
    bus.m_req = 1'b0;
    step();
    chk("capt_strobe", {31'd0, bus.reg_read}, 32'd0);
    chk("capt_addr", {18'd0, bus.reg_address}, 32'h21);
    chk("capt_nodone", {31'd0, bus.m_done}, 32'd0);
    step();
    chk("rd_done", {31'd0, bus.m_done}, 32'd1);
    chk("rd_err", {31'd0, bus.m_err}, 32'd0);
    chk("rd_data", {24'd0, bus.m_rdata}, 32'h3C);
    chk("u_datai", {24'd0, bus.u_datai}, 32'h3C);
    step();

    // USB read collides during CAPT
    bus.m_req = 1'b1;
    bus.m_address = 14'h0022;
    bus.reg_datai = 8'h99;
    step();
    chk("col_gnt", {31'd0, bus.m_gnt}, 32'd1);
    bus.m_req = 1'b0;
    step();
    bus.u_read = 1'b1;
    bus.u_address = 14'h0005;
    bus.u_addrvalid = 1'b1;
    bus.u_cen_early = 1'b0;
    #1;
    chk("col_addr", {18'd0, bus.reg_address}, 32'h5);
    chk("col_rd", {31'd0, bus.reg_read}, 32'd1);
    step();
    chk("col_done", {31'd0, bus.m_done}, 32'd1);
    chk("col_err", {31'd0, bus.m_err}, 32'd1);
    chk("col_rdata", {24'd0, bus.m_rdata}, 32'h3C);
    chk("col_abort", {24'd0, bus.abort_cnt}, 32'h01);
    bus.u_read = 1'b0;
    bus.u_addrvalid = 1'b0;
    bus.u_cen_early = 1'b1;

    // 299 more collisions in ISSUE: counter must stop at 255
    bus.m_we = 1'b1;
    for (int i = 0; i < 299; i++) begin
      bus.m_req = 1'b1;
      wait_gnt();
      bus.m_req = 1'b0;
      bus.u_write = 1'b1;
      bus.u_cen_early = 1'b0;
      step();
      bus.u_write = 1'b0;
      bus.u_cen_early = 1'b1;
    end
    #1;
    chk("sat_err", {31'd0, bus.m_err}, 32'd1);
    chk("sat_abort", {24'd0, bus.abort_cnt}, 32'hFF);

    // reset while in ISSUE
    bus.m_req = 1'b1;
    bus.m_address = 14'h0030;
    bus.m_wdata = 8'h5A;
    wait_gnt();
    bus.m_req = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_iss_wr", {31'd0, bus.reg_write}, 32'd0);
    step();
    chk("rst_iss_done", {31'd0, bus.m_done}, 32'd0);
    chk("rst_iss_gnt", {31'd0, bus.m_gnt}, 32'd0);
    chk("rst_iss_abort", {24'd0, bus.abort_cnt}, 32'h00);
    chk("rst_iss_rdata", {24'd0, bus.m_rdata}, 32'h00);
    rst = 1'b0;
    step();
    chk("post_rst_done", {31'd0, bus.m_done}, 32'd0);
    chk("post_rst_wr", {31'd0, bus.reg_write}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
